mem_lsu_master: RTL and testbench

//   Load/store initiator for the core's word-wide memory port.

---
 rtl/mem_lsu_master.sv | 156 +++++++++++++++
 tb/tb_mem_lsu_master.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_lsu_master.sv
// Load/store initiator for a word-wide synchronous memory port.
// One RV32I load/store per handshake; returns extended load data or an access error.
module mem_lsu_master #(
   parameter int ADDR_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid_i,
   output logic                  req_ready_o,
   input  logic                  req_we_i,
   input  logic [2:0]            req_funct3_i,
   input  logic [ADDR_WIDTH-1:0] req_addr_i,
   input  logic [31:0]           req_wdata_i,
   output logic                  rsp_valid_o,
   input  logic                  rsp_ready_i,
   output logic [31:0]           rsp_rdata_o,
   output logic                  rsp_err_o,
   output logic [ADDR_WIDTH-1:0] mem_addr_o,
   output logic                  mem_rstrb_o,
   input  logic [31:0]           mem_rdata_i,
   output logic [3:0]            mem_wmask_o,
   output logic [31:0]           mem_wdata_o
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   state_t                state_q;
   logic                  we_q;
   logic [2:0]            funct3_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [31:0]           wdata_q;
   logic                  rstrb_q;
   logic [3:0]            wmask_q;
   logic                  rsp_valid_q;
   logic                  rsp_err_q;
   logic [31:0]           rsp_rdata_q;

   logic                  req_err_d;
   logic [3:0]            wmask_d;
   logic [31:0]           wdata_d;
   logic [31:0]           shifted_d;
   logic [31:0]           load_data_d;

   // Decode of the incoming request: legality, alignment, lane mask and replicated data.
   always_comb begin
      req_err_d = 1'b0;
      wmask_d   = 4'b0000;
      wdata_d   = req_wdata_i;
      if (req_we_i) begin
         case (req_funct3_i)
            3'd0: begin
               wmask_d = 4'b0001 << req_addr_i[1:0];
               wdata_d = {4{req_wdata_i[7:0]}};
            end
            3'd1: begin
               wmask_d   = 4'b0011 << req_addr_i[1:0];
               wdata_d   = {2{req_wdata_i[15:0]}};
               req_err_d = req_addr_i[0];
            end
            3'd2: begin
               wmask_d   = 4'b1111;
               req_err_d = |req_addr_i[1:0];
            end
            default: req_err_d = 1'b1;
         endcase
      end else begin
         case (req_funct3_i)
            3'd0, 3'd4: req_err_d = 1'b0;
            3'd1, 3'd5: req_err_d = req_addr_i[0];
            3'd2:       req_err_d = |req_addr_i[1:0];
            default:    req_err_d = 1'b1;
         endcase
      end
   end

   always_comb begin
      shifted_d   = mem_rdata_i >> {addr_q[1:0], 3'b000};
      load_data_d = shifted_d;
      case (funct3_q)
         3'd0:    load_data_d = {{24{shifted_d[7]}}, shifted_d[7:0]};
         3'd1:    load_data_d = {{16{shifted_d[15]}}, shifted_d[15:0]};
         3'd4:    load_data_d = {24'd0, shifted_d[7:0]};
         3'd5:    load_data_d = {16'd0, shifted_d[15:0]};
         default: load_data_d = shifted_d;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         we_q        <= 1'b0;
         funct3_q    <= 3'd0;
         addr_q      <= '0;
         wdata_q     <= 32'd0;
         rstrb_q     <= 1'b0;
         wmask_q     <= 4'b0000;
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         rsp_rdata_q <= 32'd0;
      end else begin
         case (state_q)
            IDLE: begin
               if (req_valid_i) begin
                  we_q        <= req_we_i;
                  funct3_q    <= req_funct3_i;
                  addr_q      <= req_addr_i;
                  wdata_q     <= wdata_d;
                  rsp_rdata_q <= 32'd0;
                  rsp_err_q   <= req_err_d;
                  if (req_err_d) begin
                     rsp_valid_q <= 1'b1;
                     state_q     <= RESP;
                  end else begin
                     if (req_we_i) wmask_q <= wmask_d;
                     else          rstrb_q <= 1'b1;
                     state_q <= ISSUE;
                  end
               end
            end
            ISSUE: begin
               rstrb_q <= 1'b0;
               wmask_q <= 4'b0000;
               if (we_q) begin
                  rsp_valid_q <= 1'b1;
                  state_q     <= RESP;
               end else begin
                  state_q <= WAIT;
               end
            end
            WAIT: begin
               rsp_rdata_q <= load_data_d;
               rsp_valid_q <= 1'b1;
               state_q     <= RESP;
            end
            RESP: begin
               if (rsp_ready_i) begin
                  rsp_valid_q <= 1'b0;
                  state_q     <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // Outputs are forced low while rst is high so a store caught in ISSUE cannot write at the rst edge.
   assign req_ready_o = ~rst & (state_q == IDLE);
   assign rsp_valid_o = ~rst & rsp_valid_q;
   assign rsp_rdata_o = rst ? 32'd0 : rsp_rdata_q;
   assign rsp_err_o   = ~rst & rsp_err_q;
   assign mem_addr_o  = rst ? '0 : {addr_q[ADDR_WIDTH-1:2], 2'b00};
   assign mem_rstrb_o = ~rst & rstrb_q;
   assign mem_wmask_o = rst ? 4'b0000 : wmask_q;
   assign mem_wdata_o = rst ? 32'd0 : wdata_q;

endmodule

// File: tb/tb_mem_lsu_master.sv
// Directed bench for mem_lsu_master with a small byte-masked word memory behind the port.
module tb_mem_lsu_master;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid_i = 1'b0;
   logic        req_ready_o;
   logic        req_we_i = 1'b0;
   logic [2:0]  req_funct3_i = 3'd0;
   logic [31:0] req_addr_i = 32'd0;
   logic [31:0] req_wdata_i = 32'd0;
   logic        rsp_valid_o;
   logic        rsp_ready_i = 1'b1;
   logic [31:0] rsp_rdata_o;
   logic        rsp_err_o;
   logic [31:0] mem_addr_o;
   logic        mem_rstrb_o;
   logic [31:0] mem_rdata_i = 32'd0;
   logic [3:0]  mem_wmask_o;
   logic [31:0] mem_wdata_o;

   logic [31:0] mem [0:63];
   logic        pl_en = 1'b0;
   logic [5:0]  pl_idx = 6'd0;
   logic [31:0] pl_data = 32'd0;
   int          act_cnt = 0;

   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   mem_lsu_master #(.ADDR_WIDTH(32)) dut (
      .clk(clk), .rst(rst),
      .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
      .req_we_i(req_we_i), .req_funct3_i(req_funct3_i),
      .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
      .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
      .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
      .mem_addr_o(mem_addr_o), .mem_rstrb_o(mem_rstrb_o),
      .mem_rdata_i(mem_rdata_i), .mem_wmask_o(mem_wmask_o),
      .mem_wdata_o(mem_wdata_o)
   );

   // Memory model: registered read, byte-masked write at the clock edge, plus a preload port.
   always @(posedge clk) begin
      if (pl_en) mem[pl_idx] <= pl_data;
      if (mem_rstrb_o) mem_rdata_i <= mem[mem_addr_o[7:2]];
      for (int b = 0; b < 4; b++)
         if (mem_wmask_o[b]) mem[mem_addr_o[7:2]][8*b +: 8] <= mem_wdata_o[8*b +: 8];
   end

   always @(negedge clk)
      if (mem_rstrb_o || (mem_wmask_o != 4'b0000)) act_cnt <= act_cnt + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic preload(input logic [5:0] idx, input logic [31:0] data);
      @(negedge clk);
      pl_en = 1'b1; pl_idx = idx; pl_data = data;
      @(posedge clk); #1;
      pl_en = 1'b0;
   endtask

   // One transaction with rsp_ready_i high; lat counts edges after the accept edge until rsp_valid_o.
   task automatic xact(input logic we, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] d, output logic [31:0] rd, output logic e,
                       output int lat, output logic [3:0] mask_s, output logic [31:0] wd_s);
      @(negedge clk);
      req_valid_i = 1'b1; req_we_i = we; req_funct3_i = f3;
      req_addr_i = a; req_wdata_i = d;
      chk("req_ready_before_accept", {31'd0, req_ready_o}, 32'd1);
      @(posedge clk); #1;
      req_valid_i = 1'b0;
      @(negedge clk);
      mask_s = mem_wmask_o;
      wd_s   = mem_wdata_o;
      lat = 0;
      while (!rsp_valid_o && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      rd = rsp_rdata_o;
      e  = rsp_err_o;
      @(posedge clk); #1;
   endtask

   initial begin
      logic [31:0] rd, hold;
      logic        e;
      logic [3:0]  ms;
      logic [31:0] ws;
      int          lat, act0;

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_req_ready", {31'd0, req_ready_o}, 32'd0);
      chk("rst_rsp_valid", {31'd0, rsp_valid_o}, 32'd0);
      chk("rst_rstrb", {31'd0, mem_rstrb_o}, 32'd0);
      chk("rst_wmask", {28'd0, mem_wmask_o}, 32'd0);
      chk("rst_addr", mem_addr_o, 32'd0);
      rst = 1'b0;
      #1;
      chk("idle_req_ready", {31'd0, req_ready_o}, 32'd1);
      $display("reset released");

      // 1: loads with extension
      preload(6'd4, 32'h8070_F0A1);
      xact(1'b0, 3'd0, 32'h10, 32'd0, rd, e, lat, ms, ws);
      $display("LB  @10 rdata=%h err=%0d lat=%0d", rd, e, lat);
      chk("lb_data", rd, 32'hFFFF_FFA1); chk("lb_lat", lat, 32'd2);
      xact(1'b0, 3'd4, 32'h11, 32'd0, rd, e, lat, ms, ws);
      $display("LBU @11 rdata=%h err=%0d lat=%0d", rd, e, lat);
      chk("lbu_data", rd, 32'h0000_00F0); chk("lbu_lat", lat, 32'd2);
      xact(1'b0, 3'd1, 32'h12, 32'd0, rd, e, lat, ms, ws);
      $display("LH  @12 rdata=%h err=%0d lat=%0d", rd, e, lat);
      chk("lh_data", rd, 32'hFFFF_8070); chk("lh_lat", lat, 32'd2);
      xact(1'b0, 3'd2, 32'h10, 32'd0, rd, e, lat, ms, ws);
      $display("LW  @10 rdata=%h err=%0d lat=%0d", rd, e, lat);
      chk("lw_data", rd, 32'h8070_F0A1); chk("lw_lat", lat, 32'd2);
      chk("lw_err", {31'd0, e}, 32'd0);

      // 2: byte store into lane 3
      preload(6'd8, 32'h1122_3344);
      xact(1'b1, 3'd0, 32'h23, 32'h0000_0055, rd, e, lat, ms, ws);
      $display("SB  @23 mask=%b wdata=%h rdata=%h lat=%0d", ms, ws, rd, lat);
      chk("sb_mask", {28'd0, ms}, 32'h8); chk("sb_wdata", ws, 32'h5555_5555);
      chk("sb_lat", lat, 32'd1); chk("sb_rdata", rd, 32'd0);
      xact(1'b0, 3'd2, 32'h20, 32'd0, rd, e, lat, ms, ws);
      $display("LW  @20 rdata=%h err=%0d lat=%0d", rd, e, lat);
      chk("sb_readback", rd, 32'h5522_3344);

      // 3: misaligned accesses
      act0 = act_cnt;
      xact(1'b0, 3'd2, 32'h22, 32'd0, rd, e, lat, ms, ws);
      $display("LW  @22 rdata=%h err=%0d lat=%0d", rd, e, lat);
      chk("lw_mis_err", {31'd0, e}, 32'd1); chk("lw_mis_rdata", rd, 32'd0);
      chk("lw_mis_lat", lat, 32'd0);
      xact(1'b1, 3'd1, 32'h31, 32'h0000_BEEF, rd, e, lat, ms, ws);
      $display("SH  @31 rdata=%h err=%0d lat=%0d", rd, e, lat);
      chk("sh_mis_err", {31'd0, e}, 32'd1); chk("sh_mis_rdata", rd, 32'd0);
      chk("sh_mis_lat", lat, 32'd0);
      xact(1'b0, 3'd6, 32'h10, 32'd0, rd, e, lat, ms, ws);
      $display("L6  @10 rdata=%h err=%0d lat=%0d", rd, e, lat);
      chk("illegal_err", {31'd0, e}, 32'd1);
      chk("err_no_mem_activity", act_cnt - act0, 32'd0);

      // 4: response back-pressure
      @(negedge clk);
      rsp_ready_i = 1'b0;
      req_valid_i = 1'b1; req_we_i = 1'b0; req_funct3_i = 3'd5; req_addr_i = 32'h12;
      @(posedge clk); #1;
      req_valid_i = 1'b0;
      lat = 0;
      @(negedge clk);
      while (!rsp_valid_o && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      hold = rsp_rdata_o;
      $display("LHU @12 rdata=%h lat=%0d (held)", hold, lat);
      chk("bp_lat", lat, 32'd2); chk("bp_data", hold, 32'h0000_8070);
      act0 = act_cnt;
      req_valid_i = 1'b1; req_we_i = 1'b1; req_funct3_i = 3'd2;
      req_addr_i = 32'h10; req_wdata_i = 32'hDEAD_BEEF;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); @(negedge clk);
         chk("bp_valid", {31'd0, rsp_valid_o}, 32'd1);
         chk("bp_rdata", rsp_rdata_o, hold);
         chk("bp_ready", {31'd0, req_ready_o}, 32'd0);
      end
      req_valid_i = 1'b0;
      rsp_ready_i = 1'b1;
      @(posedge clk); @(negedge clk);
      chk("bp_release", {31'd0, rsp_valid_o}, 32'd0);
      chk("bp_ignored_activity", act_cnt - act0, 32'd0);
      chk("bp_ignored_mem", mem[4], 32'h8070_F0A1);
      $display("backpressure done mem[10]=%h", mem[4]);

      // 5: reset during the ISSUE cycle of a store
      preload(6'd12, 32'hCAFE_BABE);
      @(negedge clk);
      req_valid_i = 1'b1; req_we_i = 1'b1; req_funct3_i = 3'd2;
      req_addr_i = 32'h30; req_wdata_i = 32'h1234_5678;
      @(posedge clk); #1;
      req_valid_i = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      chk("rst_issue_wmask", {28'd0, mem_wmask_o}, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("rst_issue_ready", {31'd0, req_ready_o}, 32'd1);
      chk("rst_issue_wmask_after", {28'd0, mem_wmask_o}, 32'd0);
      chk("rst_issue_mem", mem[12], 32'hCAFE_BABE);
      repeat (3) begin
         @(negedge clk);
         chk("rst_issue_no_rsp", {31'd0, rsp_valid_o}, 32'd0);
      end
      $display("SW  @30 reset in ISSUE mem[30]=%h", mem[12]);

      // 6: back-to-back store then load
      xact(1'b1, 3'd2, 32'h3C, 32'hA5A5_5A5A, rd, e, lat, ms, ws);
      $display("SW  @3C mask=%b wdata=%h lat=%0d", ms, ws, lat);
      chk("sw_mask", {28'd0, ms}, 32'hF); chk("sw_lat", lat, 32'd1);
      xact(1'b0, 3'd2, 32'h3C, 32'd0, rd, e, lat, ms, ws);
      $display("LW  @3C rdata=%h err=%0d lat=%0d", rd, e, lat);
      chk("b2b_data", rd, 32'hA5A5_5A5A);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule
